lcd_line_arbiter: RTL and testbench

//  Shares the 16x2 character LCD (4-bit bus) between two requesters. Each requester sends a 16-char line.

---
 rtl/lcd_line_arbiter_if.sv | 13 +
 rtl/lcd_line_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_lcd_line_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_line_arbiter_if.sv
// Request side of the LCD line arbiter: line-write requests, text, row select and status.
interface lcd_line_arbiter_if;
    logic [1:0]   req;
    logic [1:0]   row;
    logic [127:0] text0;
    logic [127:0] text1;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic         busy;

    modport master (output req, row, text0, text1, input gnt, done, busy);
    modport slave  (input req, row, text0, text1, output gnt, done, busy);
endinterface

// File: rtl/lcd_line_arbiter.sv
// Shares a 4-bit HD44780-style 16x2 LCD between two line writers; runs power-on init once.
// Optional build macro LCD_ARB_FIXED_PRIO_EN: req[0] always wins ties (no round-robin pointer).
module lcd_line_arbiter #(
    parameter int TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    lcd_line_arbiter_if.slave arb,
    output logic              lcd_rs,
    output logic              lcd_w,
    output logic              lcd_e,
    output logic [3:0]        data
);
    localparam int            CW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [1:0]    PH_SET    = 2'd0;
    localparam logic [1:0]    PH_HIGH   = 2'd1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ADDR, S_CHAR} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [5:0]    nib, nib_n;
    logic [1:0]    phase, phase_n;
    logic          rs_n, e_n;
    logic [3:0]    data_n;
    logic [1:0]    gnt_q, gnt_n, done_q, done_n;
    logic          busy_q, busy_n;
    logic          owner, owner_n;
    logic          win, load, tick;
    logic          row_q;
    logic [127:0]  text_q;
    logic [4:0]    char_pos;
    logic [7:0]    ch, addr_cmd;
    logic [3:0]    cur_nib;
`ifndef LCD_ARB_FIXED_PRIO_EN
    logic          rr, rr_n;
`endif

    function automatic logic [3:0] init_nibble(input logic [5:0] idx);
        case (idx)
            6'd0, 6'd1, 6'd2: init_nibble = 4'h3;
            6'd3, 6'd4:       init_nibble = 4'h2;
            6'd5:             init_nibble = 4'h8;
            6'd7:             init_nibble = 4'h6;
            6'd9:             init_nibble = 4'hC;
            6'd11:            init_nibble = 4'h1;
            default:          init_nibble = 4'h0;
        endcase
    endfunction

    assign tick      = (cnt == TICK_LAST);
    assign lcd_w     = 1'b0;
    assign arb.gnt   = gnt_q;
    assign arb.done  = done_q;
    assign arb.busy  = busy_q;

    // Nibble index 2..33 maps to char (idx-2)/2, high nibble first; char 0 sits in text[127:120].
    always_comb begin
        char_pos = 5'(nib - 6'd2);
        ch       = text_q[{~char_pos[4:1], 3'b000} +: 8];
        addr_cmd = row_q ? 8'hC0 : 8'h80;
        case (state)
            S_INIT:  cur_nib = init_nibble(nib);
            S_ADDR:  cur_nib = nib[0] ? addr_cmd[3:0] : addr_cmd[7:4];
            S_CHAR:  cur_nib = char_pos[0] ? ch[3:0] : ch[7:4];
            default: cur_nib = 4'h0;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + 1'b1;
        nib_n   = nib;
        phase_n = phase;
        rs_n    = lcd_rs;
        data_n  = data;
        e_n     = lcd_e;
        gnt_n   = 2'b00;
        done_n  = 2'b00;
        busy_n  = busy_q;
        owner_n = owner;
        load    = 1'b0;
`ifdef LCD_ARB_FIXED_PRIO_EN
        win     = ~arb.req[0];
`else
        rr_n    = rr;
        win     = (&arb.req) ? ~rr : arb.req[1];
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (|arb.req) begin
                    load    = 1'b1;
                    owner_n = win;
                    gnt_n   = win ? 2'b10 : 2'b01;
                    busy_n  = 1'b1;
                    nib_n   = 6'd0;
                    phase_n = PH_SET;
                    state_n = S_ADDR;
`ifndef LCD_ARB_FIXED_PRIO_EN
                    rr_n    = win;
`endif
                end
            end
            default: begin
                if (tick) begin
                    case (phase)
                        PH_SET: begin
                            rs_n    = (state == S_CHAR);
                            data_n  = cur_nib;
                            e_n     = 1'b0;
                            phase_n = PH_HIGH;
                        end
                        PH_HIGH: begin
                            e_n     = 1'b1;
                            phase_n = 2'd2;
                        end
                        default: begin
                            // Falling E completes the nibble; rs/data stay put until the next PH_SET.
                            e_n     = 1'b0;
                            phase_n = PH_SET;
                            nib_n   = nib + 6'd1;
                            if (state == S_INIT && nib == 6'd11) begin
                                state_n = S_IDLE;
                                busy_n  = 1'b0;
                                nib_n   = 6'd0;
                            end else if (state == S_ADDR && nib == 6'd1) begin
                                state_n = S_CHAR;
                            end else if (state == S_CHAR && nib == 6'd33) begin
                                state_n = S_IDLE;
                                busy_n  = 1'b0;
                                nib_n   = 6'd0;
                                done_n  = owner ? 2'b10 : 2'b01;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_INIT;
            cnt    <= '0;
            nib    <= 6'd0;
            phase  <= PH_SET;
            lcd_rs <= 1'b0;
            data   <= 4'h0;
            lcd_e  <= 1'b0;
            gnt_q  <= 2'b00;
            done_q <= 2'b00;
            busy_q <= 1'b1;
            owner  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            nib    <= nib_n;
            phase  <= phase_n;
            lcd_rs <= rs_n;
            data   <= data_n;
            lcd_e  <= e_n;
            gnt_q  <= gnt_n;
            done_q <= done_n;
            busy_q <= busy_n;
            owner  <= owner_n;
        end
    end

`ifndef LCD_ARB_FIXED_PRIO_EN
    // Pointer holds the last winner; reset value makes requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) rr <= 1'b1;
        else     rr <= rr_n;
    end
`endif

    always_ff @(posedge clk) begin
        if (load) begin
            row_q  <= win ? arb.row[1] : arb.row[0];
            text_q <= win ? arb.text1 : arb.text0;
        end
    end
endmodule

// File: tb/tb_lcd_line_arbiter.sv
// Directed/randomized bench for lcd_line_arbiter with a line-level reference model.
module tb_lcd_line_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_rs, lcd_w, lcd_e;
    logic [3:0] data;

    lcd_line_arbiter_if arb();

    lcd_line_arbiter #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .arb(arb),
        .lcd_rs(lcd_rs), .lcd_w(lcd_w), .lcd_e(lcd_e), .data(data)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] cap[$];
    logic [4:0] exp_q[$];
    logic       prev_e = 1'b0;
    int         gnt_cnt = 0;
    int         done_cnt = 0;
    int         last_w = 1;
    int         cur_w = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Bus monitor: one {rs,data} entry per rising E, plus invariants every cycle.
    always @(negedge clk) begin
        if (lcd_e === 1'b1 && prev_e === 1'b0) cap.push_back({lcd_rs, data});
        prev_e = lcd_e;
        if (arb.gnt !== 2'b00) gnt_cnt++;
        if (arb.done !== 2'b00) done_cnt++;
        check("lcd_w_low", 32'(lcd_w), 32'd0);
        check("gnt_onehot", 32'($countones(arb.gnt) <= 1), 32'd1);
        check("gnt_done_overlap", 32'(arb.gnt & arb.done), 32'd0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int predict(input logic [1:0] rq);
`ifdef LCD_ARB_FIXED_PRIO_EN
        return rq[0] ? 0 : 1;
`else
        if (rq == 2'b11) return 1 - last_w;
        return rq[0] ? 0 : 1;
`endif
    endfunction

    task automatic build_exp(input logic r, input logic [127:0] t);
        logic [7:0] a;
        logic [7:0] c;
        exp_q.delete();
        a = 8'h80 | (8'(r) << 6);
        exp_q.push_back({1'b0, a[7:4]});
        exp_q.push_back({1'b0, a[3:0]});
        for (int k = 0; k < 16; k++) begin
            c = t[127 - 8*k -: 8];
            exp_q.push_back({1'b1, c[7:4]});
            exp_q.push_back({1'b1, c[3:0]});
        end
    endtask

    task automatic compare_exp(input string tag);
        check({tag, "_count"}, 32'(cap.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < cap.size()) check(tag, 32'(cap[i]), 32'(exp_q[i]));
    endtask

    task automatic reset_init(input logic [1:0] req_mid);
        int n;
        int d0;
        logic [3:0] init_seq [12];
        init_seq = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(arb.busy), 32'd1);
        check("rst_e", 32'(lcd_e), 32'd0);
        check("rst_rs", 32'(lcd_rs), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_gnt", 32'(arb.gnt), 32'd0);
        check("rst_done", 32'(arb.done), 32'd0);
        rst = 1'b0;
        cap.delete();
        last_w = 1;
        d0 = done_cnt;
        n = 0;
        while (arb.busy === 1'b1 && n < 1000) begin
            if (n == 60) arb.req = req_mid;
            @(negedge clk);
            n++;
        end
        check("init_busy_clks", 32'(n), 32'd144);
        exp_q.delete();
        for (int i = 0; i < 12; i++) exp_q.push_back({1'b0, init_seq[i]});
        compare_exp("init_nibble");
        check("init_no_done", 32'(done_cnt - d0), 32'd0);
        check("init_end_no_gnt", 32'(arb.gnt), 32'd0);
    endtask

    task automatic take_grant(input string tag, input logic [1:0] rq);
        int w;
        w = predict(rq);
        check(tag, 32'(arb.gnt), (w == 1) ? 32'd2 : 32'd1);
        last_w = w;
        cur_w = w;
        build_exp(arb.row[w], (w == 1) ? arb.text1 : arb.text0);
        cap.delete();
        // Changing the text after the grant must not affect the line being written.
        arb.text0 = {$urandom, $urandom, $urandom, $urandom};
        arb.text1 = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic finish_txn(input logic [1:0] pulse);
        int k;
        k = 0;
        while (arb.done === 2'b00 && k < 1000) begin
            if (pulse != 2'b00 && k == 20) arb.req = pulse;
            if (pulse != 2'b00 && k == 40) arb.req = 2'b00;
            @(negedge clk);
            k++;
        end
        check("done_latency", 32'(k), 32'd408);
        check("done_who", 32'(arb.done), (cur_w == 1) ? 32'd2 : 32'd1);
        check("busy_at_done", 32'(arb.busy), 32'd0);
        compare_exp("line_nibble");
    endtask

    initial begin
        int g0;
        int n;
        arb.req   = 2'b00;
        arb.row   = 2'b00;
        arb.text0 = '0;
        arb.text1 = '0;
        reset_init(2'b00);

        // Both requesters held, requester 1 on line 2.
        arb.row   = 2'b10;
        arb.text0 = {$urandom, $urandom, $urandom, $urandom};
        arb.text1 = {$urandom, $urandom, $urandom, $urandom};
        arb.req   = 2'b11;
        @(negedge clk);
        take_grant("gnt_both_first", 2'b11);
        for (int i = 0; i < 3; i++) begin
            finish_txn(2'b00);
            @(negedge clk);
            take_grant("gnt_both_next", 2'b11);
        end
        arb.req = 2'b00;
        finish_txn(2'b00);
        g0 = gnt_cnt;
        repeat (10) @(negedge clk);
        check("idle_no_spurious_gnt", 32'(gnt_cnt - g0), 32'd0);

        // Single requester, fixed text; requester 1 pulses req while busy and drops it.
        arb.row   = 2'b00;
        arb.text0 = "HELLO WORLD     ";
        arb.req   = 2'b01;
        @(negedge clk);
        take_grant("gnt_single", 2'b01);
        arb.req = 2'b00;
        finish_txn(2'b10);
        g0 = gnt_cnt;
        repeat (20) @(negedge clk);
        check("dropped_req_no_gnt", 32'(gnt_cnt - g0), 32'd0);

        // Reset while char 7 is on the bus; a request raised during re-init is held.
        arb.row   = {1'($urandom_range(0, 1)), 1'b0};
        arb.text1 = {$urandom, $urandom, $urandom, $urandom};
        arb.req   = 2'b10;
        @(negedge clk);
        take_grant("gnt_pre_reset", 2'b10);
        arb.req = 2'b00;
        n = 0;
        while (cap.size() < 16 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reached_char7", 32'(cap.size() >= 16), 32'd1);
        arb.row   = {1'b0, 1'($urandom_range(0, 1))};
        arb.text0 = {$urandom, $urandom, $urandom, $urandom};
        reset_init(2'b01);
        @(negedge clk);
        take_grant("gnt_after_init", 2'b01);
        arb.req = 2'b00;
        finish_txn(2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
